// File: rtl/riscv_chk_pkg.sv
// Shared types and constants for the RV32I commit checker.
`default_nettype none

package riscv_chk_pkg;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_RUN   = 2'd1,
    CHK_CHECK = 2'd2,
    CHK_DONE  = 2'd3
  } chk_state_t;

  // jal x0,0 : the core spins on itself once the program is finished
  localparam logic [31:0] HALT_JAL_SELF = 32'h0000_006F;

  typedef struct packed {
    logic        valid;
    logic [4:0]  regsel;
    logic [31:0] val;
  } exp_entry_t;

endpackage

`default_nettype wire

// File: rtl/shadow_regfile.sv
// Shadow architectural register file: one write port, one async read port, x0 reads zero.
`default_nettype none

module shadow_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr_i,
  output logic [XLEN-1:0]          rdata_o
);

  localparam int REG_W = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS-1:1];

  // x0 has no storage; clear has priority so a run always starts from zero
  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[g] <= '0;
      end else if (clr_i) begin
        regs_q[g] <= '0;
      end else if (we_i && (waddr_i == REG_W'(g))) begin
        regs_q[g] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (raddr_i != '0) begin
      rdata_o = regs_q[raddr_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/commit_checker.sv
// Retire-stream monitor: tracks a shadow register file, detects halt/timeout,
// then sweeps an expectation table and reports pass/fail/timeout.
`default_nettype none

module commit_checker
  import riscv_chk_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          NREGS      = 32,
  parameter int          NUM_CHECKS = 8,
  parameter int          MAX_CYCLES = 100000,
  parameter logic [31:0] HALT_INSTR = HALT_JAL_SELF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            exp_we,
  input  logic [$clog2(NUM_CHECKS)-1:0]   exp_idx,
  input  logic                            exp_valid,
  input  logic [$clog2(NREGS)-1:0]        exp_reg,
  input  logic [XLEN-1:0]                 exp_val,
  input  logic                            ret_valid,
  input  logic [31:0]                     ret_instr,
  input  logic                            wb_en,
  input  logic [$clog2(NREGS)-1:0]        wb_rd,
  input  logic [XLEN-1:0]                 wb_data,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [$clog2(NUM_CHECKS+1)-1:0] fail_count,
  output logic [$clog2(NUM_CHECKS)-1:0]   first_fail_idx,
  output logic [$clog2(MAX_CYCLES+1)-1:0] cycle_count,
  output logic [31:0]                     retire_count
);

  localparam int IDX_W = $clog2(NUM_CHECKS);
  localparam int REG_W = $clog2(NREGS);
  localparam int FC_W  = $clog2(NUM_CHECKS + 1);
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  chk_state_t       state_q, state_d;
  logic [IDX_W-1:0] chk_idx_q, chk_idx_d;
  logic [FC_W-1:0]  fail_count_q, fail_count_d;
  logic [IDX_W-1:0] first_fail_q, first_fail_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [31:0]      retire_count_q, retire_count_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  logic [NUM_CHECKS-1:0] tbl_valid_q;
  logic [REG_W-1:0]      tbl_reg_q [NUM_CHECKS];
  logic [XLEN-1:0]       tbl_val_q [NUM_CHECKS];

  logic             w_idle_or_done;
  logic             w_start;
  logic             w_halt;
  logic             w_shadow_we;
  logic [XLEN-1:0]  w_rdata;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_cycle_inc;

  assign w_idle_or_done = (state_q == CHK_IDLE) || (state_q == CHK_DONE);
  assign w_start        = start && w_idle_or_done;
  assign w_halt         = ret_valid && (ret_instr == HALT_INSTR);
  assign w_shadow_we    = (state_q == CHK_RUN) && wb_en && (wb_rd != '0);
  assign w_cycle_inc    = cycle_count_q + CNT_W'(1);
  assign w_mismatch     = (state_q == CHK_CHECK) && tbl_valid_q[chk_idx_q] &&
                          (w_rdata != tbl_val_q[chk_idx_q]);

  shadow_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (w_start),
    .we_i    (w_shadow_we),
    .waddr_i (wb_rd),
    .wdata_i (wb_data),
    .raddr_i (tbl_reg_q[chk_idx_q]),
    .rdata_o (w_rdata)
  );

  // The table survives start; only reset drops the valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid_q <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_reg_q[i] <= '0;
        tbl_val_q[i] <= '0;
      end
    end else if (exp_we && w_idle_or_done) begin
      tbl_valid_q[exp_idx] <= exp_valid;
      tbl_reg_q[exp_idx]   <= exp_reg;
      tbl_val_q[exp_idx]   <= exp_val;
    end
  end

  always_comb begin
    state_d        = state_q;
    chk_idx_d      = chk_idx_q;
    fail_count_d   = fail_count_q;
    first_fail_d   = first_fail_q;
    cycle_count_d  = cycle_count_q;
    retire_count_d = retire_count_q;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    case (state_q)
      CHK_IDLE, CHK_DONE: begin
        if (w_start) begin
          state_d        = CHK_RUN;
          chk_idx_d      = '0;
          fail_count_d   = '0;
          first_fail_d   = '0;
          cycle_count_d  = '0;
          retire_count_d = '0;
          pass_d         = 1'b0;
          timeout_d      = 1'b0;
        end
      end
      CHK_RUN: begin
        cycle_count_d = w_cycle_inc;
        if (ret_valid && (retire_count_q != '1)) begin
          retire_count_d = retire_count_q + 32'd1;
        end
        // Halt is tested first so it wins over a coincident timeout
        if (w_halt) begin
          state_d   = CHK_CHECK;
          chk_idx_d = '0;
        end else if (w_cycle_inc == CNT_W'(MAX_CYCLES)) begin
          state_d   = CHK_DONE;
          timeout_d = 1'b1;
        end
      end
      CHK_CHECK: begin
        if (w_mismatch) begin
          fail_count_d = fail_count_q + FC_W'(1);
          if (fail_count_q == '0) begin
            first_fail_d = chk_idx_q;
          end
        end
        if (chk_idx_q == IDX_W'(NUM_CHECKS - 1)) begin
          state_d = CHK_DONE;
          pass_d  = (fail_count_d == '0);
        end else begin
          chk_idx_d = chk_idx_q + IDX_W'(1);
        end
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= CHK_IDLE;
      chk_idx_q      <= '0;
      fail_count_q   <= '0;
      first_fail_q   <= '0;
      cycle_count_q  <= '0;
      retire_count_q <= '0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      chk_idx_q      <= chk_idx_d;
      fail_count_q   <= fail_count_d;
      first_fail_q   <= first_fail_d;
      cycle_count_q  <= cycle_count_d;
      retire_count_q <= retire_count_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
    end
  end

  assign busy           = (state_q == CHK_RUN) || (state_q == CHK_CHECK);
  assign done           = (state_q == CHK_DONE);
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_q;
  assign cycle_count    = cycle_count_q;
  assign retire_count   = retire_count_q;

endmodule

`default_nettype wire
